// File: rtl/cacheline_pkg.sv
// Shared types and helpers for the cacheline memory scheduler.
package cacheline_pkg;

  localparam int LINE_W     = 256;
  localparam int LINE_OFF_W = 5;
  localparam int ADDR_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    RESP
  } sched_state_t;

  typedef enum logic [1:0] {
    OWN_D,
    OWN_I,
    OWN_PF
  } owner_t;

  // Clear the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_MAX_W-1:0] line_align(input logic [ADDR_MAX_W-1:0] addr);
    return {addr[ADDR_MAX_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_prio_select.sv
// Combinational winner picker: D > I > PF, with a starved I-cache promoted
// above D. Flush blocks the I-side and prefetch requesters for the cycle.
module cacheline_prio_select
  import cacheline_pkg::*;
(
  input  logic   d_req,
  input  logic   i_req,
  input  logic   pf_req,
  input  logic   flush,
  input  logic   starve_hit,
  output owner_t owner,
  output logic   valid
);

  // Pick the highest-priority eligible requester.
  always_comb begin
    owner = OWN_D;
    valid = 1'b0;
    if (i_req && !flush && starve_hit) begin
      owner = OWN_I;
      valid = 1'b1;
    end else if (d_req) begin
      owner = OWN_D;
      valid = 1'b1;
    end else if (i_req && !flush) begin
      owner = OWN_I;
      valid = 1'b1;
    end else if (pf_req && !i_req && !flush) begin
      owner = OWN_PF;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/cacheline_mem_scheduler.sv
// Shares one cacheline memory port among D-cache, I-cache and I-prefetcher.
// Commands are single-cycle and registered; read responses are matched by
// address tag; squashed I/PF fetches are drained without a requester response.
module cacheline_mem_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = cacheline_pkg::LINE_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              pf_read,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_resp,
  output logic              busy
);

  import cacheline_pkg::*;

  sched_state_t      state, state_n;
  owner_t            owner_q, sel_owner;
  logic              sel_vld;
  logic              op_write_q;
  logic [3:0]        i_starve, i_starve_n;
  logic              starve_hit;
  logic              squashable;
  logic              complete;
  logic              grant, grant_wr, resp_n;
  logic [ADDR_W-1:0] sel_addr;

  assign starve_hit = (i_starve == 4'(STARVE_MAX));
  assign squashable = (owner_q != OWN_D);
  // Writes complete on any response; reads need the returned tag to match.
  assign complete   = mem_resp && (op_write_q || (mem_raddr == mem_addr));

  cacheline_prio_select u_prio (
    .d_req      (d_read | d_write),
    .i_req      (i_read),
    .pf_req     (pf_read),
    .flush      (flush),
    .starve_hit (starve_hit),
    .owner      (sel_owner),
    .valid      (sel_vld)
  );

  // Next-state, grant, response and starvation-counter decisions.
  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    grant_wr   = 1'b0;
    resp_n     = 1'b0;
    i_starve_n = i_starve;
    case (sel_owner)
      OWN_I:   sel_addr = i_addr;
      OWN_PF:  sel_addr = pf_addr;
      default: sel_addr = d_addr;
    endcase
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant    = 1'b1;
          grant_wr = (sel_owner == OWN_D) && d_write;
          state_n  = ISSUE;
        end
      end
      ISSUE: state_n = (flush && squashable) ? DRAIN : WAIT;
      WAIT: begin
        // A response landing with the flush is consumed but not forwarded.
        if (complete) begin
          state_n = RESP;
          resp_n  = !(flush && squashable);
        end else if (flush && squashable) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (complete) state_n = IDLE;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      i_starve_n = 4'd0;
    end else if (grant && (sel_owner == OWN_I)) begin
      i_starve_n = 4'd0;
    end else if (grant && (sel_owner == OWN_D) && i_read && !starve_hit) begin
      i_starve_n = i_starve + 4'd1;
    end
  end

  // State, latched transaction and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_q    <= OWN_D;
      op_write_q <= 1'b0;
      i_starve   <= 4'd0;
      busy       <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      d_resp     <= 1'b0;
      i_resp     <= 1'b0;
      pf_resp    <= 1'b0;
      d_rdata    <= '0;
      i_rdata    <= '0;
      pf_rdata   <= '0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      i_starve  <= i_starve_n;
      mem_read  <= grant && !grant_wr;
      mem_write <= grant_wr;
      d_resp    <= resp_n && (owner_q == OWN_D);
      i_resp    <= resp_n && (owner_q == OWN_I);
      pf_resp   <= resp_n && (owner_q == OWN_PF);
      if (grant) begin
        owner_q    <= sel_owner;
        op_write_q <= grant_wr;
        mem_addr   <= ADDR_W'(line_align(ADDR_MAX_W'(sel_addr)));
      end
      if (grant_wr) mem_wdata <= d_wdata;
      if (resp_n) begin
        case (owner_q)
          OWN_I:   i_rdata  <= mem_rdata;
          OWN_PF:  pf_rdata <= mem_rdata;
          default: d_rdata  <= mem_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cacheline_mem_scheduler.sv
// Bench for cacheline_mem_scheduler: directed scenarios with a response
// scoreboard checked whenever any requester response pulses.
module tb_cacheline_mem_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [31:0]  d_addr, i_addr, pf_addr, mem_addr, mem_raddr;
  logic         d_read, d_write, i_read, pf_read;
  logic [255:0] d_wdata, d_rdata, i_rdata, pf_rdata, mem_wdata, mem_rdata;
  logic         d_resp, i_resp, pf_resp;
  logic         mem_read, mem_write, mem_resp, busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]   who;   // {pf, i, d}
    logic [255:0] data;
  } sb_t;
  sb_t sb[$];

  cacheline_mem_scheduler #(.ADDR_W(32), .LINE_W(256), .STARVE_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .d_addr    (d_addr),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .i_addr    (i_addr),
    .i_read    (i_read),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .pf_addr   (pf_addr),
    .pf_read   (pf_read),
    .pf_rdata  (pf_rdata),
    .pf_resp   (pf_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_raddr (mem_raddr),
    .mem_resp  (mem_resp),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(input string tag);
    int c;
    c = 0;
    while (!(mem_read || mem_write) && c < 20) begin
      tick(1);
      c++;
    end
    check_eq({tag, "_cmd"}, mem_read || mem_write, 1'b1);
  endtask

  // Wait for the command, check its address, answer after lat cycles.
  task automatic serve_one(input string tag, input logic [31:0] exp_addr,
                           input logic [2:0] who, input logic [255:0] data, input int lat);
    wait_cmd(tag);
    check_eq({tag, "_addr"}, mem_addr, exp_addr);
    tick(lat);
    mem_resp  = 1'b1;
    mem_raddr = exp_addr;
    mem_rdata = data;
    sb.push_back('{who, data});
    tick(1);
    mem_resp  = 1'b0;
  endtask

  always @(posedge clk) begin
    assert (!(d_read && d_write));
  end

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    sb_t e;
    if (rst && (d_resp || i_resp || pf_resp)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", {pf_resp, i_resp, d_resp}, 3'b000);
      end else begin
        e = sb.pop_front();
        check_eq("resp_who", {pf_resp, i_resp, d_resp}, e.who);
        check_eq("resp_data", e.who[0] ? d_rdata : (e.who[1] ? i_rdata : pf_rdata), e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] dat;
    rst = 1'b0; flush = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    i_addr = '0; i_read = 1'b0; pf_addr = '0; pf_read = 1'b0;
    mem_rdata = '0; mem_raddr = '0; mem_resp = 1'b0;
    tick(3);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cmd", {mem_read, mem_write}, 2'b00);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_resp", {pf_resp, i_resp, d_resp}, 3'b000);
    check_eq("rst_rdata", d_rdata, 256'h0);
    rst = 1'b1;
    tick(2);

    // Basic D read with exact cycle timing.
    dat = {8{32'h1111_2222}};
    d_addr = 32'h1000_0024; d_read = 1'b1;
    tick(1);
    check_eq("t1_mem_read", mem_read, 1'b1);
    check_eq("t1_mem_addr", mem_addr, 32'h1000_0020);
    check_eq("t1_busy", busy, 1'b1);
    tick(1);
    check_eq("t1_read_once", mem_read, 1'b0);
    tick(3);
    mem_resp = 1'b1; mem_raddr = 32'h1000_0020; mem_rdata = dat;
    sb.push_back('{3'b001, dat});
    check_eq("t1_no_early_resp", d_resp, 1'b0);
    tick(1);
    mem_resp = 1'b0;
    check_eq("t1_d_resp", d_resp, 1'b1);
    check_eq("t1_d_rdata", d_rdata, dat);
    d_read = 1'b0;
    tick(1);
    check_eq("t1_resp_once", d_resp, 1'b0);
    check_eq("t1_idle", busy, 1'b0);

    // Starvation: 8 D grants, then I is promoted.
    i_addr = 32'h2000_0000; i_read = 1'b1;
    for (int k = 0; k < 9; k++) begin
      d_addr = 32'h3000_0000 + k * 32; d_read = 1'b1;
      if (k < 8) begin
        serve_one("stv_d", d_addr, 3'b001, {8{32'hD000_0000 + k}}, 1);
        d_read = 1'b0;
      end else begin
        serve_one("stv_i", 32'h2000_0000, 3'b010, {8{32'hC0DE_0009}}, 1);
        i_read = 1'b0;
      end
      tick(1);
    end
    serve_one("stv_d9", 32'h3000_0100, 3'b001, {8{32'hD000_0099}}, 1);
    d_read = 1'b0;
    tick(1);

    // Flush while an I fetch is in WAIT: drained silently.
    i_addr = 32'h2000_0104; i_read = 1'b1;
    wait_cmd("fl");
    check_eq("fl_addr", mem_addr, 32'h2000_0100);
    tick(1);
    flush = 1'b1; i_read = 1'b0;
    tick(1);
    flush = 1'b0;
    check_eq("fl_busy_drain", busy, 1'b1);
    tick(1);
    mem_resp = 1'b1; mem_raddr = 32'h2000_0100; mem_rdata = {8{32'hBAD0_BAD0}};
    d_addr = 32'h5000_0000; d_read = 1'b1;
    tick(1);
    mem_resp = 1'b0;
    check_eq("fl_busy_drop", busy, 1'b0);
    check_eq("fl_no_cmd", mem_read, 1'b0);
    check_eq("fl_no_iresp", i_resp, 1'b0);
    tick(1);
    check_eq("fl_next_grant", mem_read, 1'b1);
    serve_one("fl_d", 32'h5000_0000, 3'b001, {8{32'h5555_0000}}, 1);
    d_read = 1'b0;
    tick(1);

    // D writeback with a garbage response tag.
    dat = {8{32'h0BAD_F00D}};
    d_addr = 32'h4000_0044; d_wdata = {32{8'hA5}}; d_write = 1'b1;
    wait_cmd("wr");
    check_eq("wr_mem_write", {mem_write, mem_read}, 2'b10);
    check_eq("wr_addr", mem_addr, 32'h4000_0040);
    check_eq("wr_wdata", mem_wdata, {32{8'hA5}});
    tick(1);
    check_eq("wr_once", mem_write, 1'b0);
    mem_resp = 1'b1; mem_raddr = 32'hDEAD_BEEF; mem_rdata = dat;
    sb.push_back('{3'b001, dat});
    tick(1);
    mem_resp = 1'b0;
    check_eq("wr_d_resp", d_resp, 1'b1);
    d_write = 1'b0;
    tick(1);

    // Prefetch first, I arrives during WAIT; stray tag ignored.
    dat = {8{32'hFE7C_0001}};
    pf_addr = 32'h6000_0040; pf_read = 1'b1;
    wait_cmd("pf");
    check_eq("pf_addr", mem_addr, 32'h6000_0040);
    tick(1);
    i_addr = 32'h7000_0000; i_read = 1'b1;
    mem_resp = 1'b1; mem_raddr = 32'h6000_0000; mem_rdata = {8{32'hEEEE_EEEE}};
    tick(1);
    mem_resp = 1'b0;
    check_eq("pf_stray_ignored", {busy, pf_resp}, 2'b10);
    tick(1);
    mem_resp = 1'b1; mem_raddr = 32'h6000_0040; mem_rdata = dat;
    sb.push_back('{3'b100, dat});
    tick(1);
    mem_resp = 1'b0;
    check_eq("pf_resp", {pf_resp, i_resp}, 2'b10);
    pf_read = 1'b0;
    tick(1);
    check_eq("pf_i_not_yet", mem_read, 1'b0);
    tick(1);
    check_eq("pf_i_grant", mem_read, 1'b1);
    serve_one("pf_i", 32'h7000_0000, 3'b010, {8{32'h1C1C_0002}}, 2);
    i_read = 1'b0;
    tick(1);

    // Async reset mid-WAIT, then a stale response.
    d_addr = 32'h8000_0000; d_read = 1'b1;
    wait_cmd("ar");
    tick(1);
    rst = 1'b0;
    #1;
    check_eq("ar_busy", busy, 1'b0);
    check_eq("ar_addr", mem_addr, 32'h0);
    d_read = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    mem_resp = 1'b1; mem_raddr = 32'h8000_0000; mem_rdata = {8{32'h57A1_E000}};
    tick(1);
    mem_resp = 1'b0;
    check_eq("ar_stale", {busy, mem_read, mem_write, d_resp}, 4'b0000);
    tick(2);
    check_eq("ar_still_idle", {busy, d_resp, d_rdata[31:0]}, 34'h0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
